downsample_engine: RTL and testbench

Parametrised, hard-wired successor to the microcoded downsampling processor: averages each non-overlapping FACTOR×FACTOR pixel window of a source image in data memory and writes one output pixel per window to a destination region. It sits beside the processor on the same data-memory port. It is generalised in data width, image size and factor, and adds a start/busy/done handshake that the instruction-driven processor does not have. A single engine run replaces a full program execution.

---
 rtl/downsample_engine.sv | 186 ++++++++++++++++++
 tb/tb_downsample_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/downsample_engine.sv
// downsample_engine: box-filter downsampler that averages FACTOR x FACTOR windows from data memory.
// Optional build macro DS_ROUND_EN selects round-half-up with saturation instead of truncation.
module downsample_engine #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned FACTOR   = 2,
  parameter int unsigned SRC_BASE = 0,
  parameter int unsigned DST_BASE = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        STATE
);

  localparam int unsigned SHIFT = 2 * $clog2(FACTOR);
  localparam int unsigned ACC_W = DATA_W + SHIFT;
  localparam int unsigned OUT_X = IMG_W / FACTOR;
  localparam int unsigned OUT_Y = IMG_H / FACTOR;
  localparam int unsigned WXW   = $clog2(FACTOR);
  localparam int unsigned OXW   = (OUT_X > 1) ? $clog2(OUT_X) : 1;
  localparam int unsigned OYW   = (OUT_Y > 1) ? $clog2(OUT_Y) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q;
  logic [OXW-1:0]      ox_q;
  logic [OYW-1:0]      oy_q;
  logic [WXW-1:0]      wx_q, wy_q;
  logic [ACC_W-1:0]    acc_q;
  logic                rd_vld_q;
  logic                rd_en_q, wr_en_q, busy_q, done_q;
  logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;

  logic                wx_last, wy_last, last_tap, ox_last, oy_last;
  logic [WXW-1:0]      wx_d, wy_d;
  logic [OXW-1:0]      ox_d;
  logic [OYW-1:0]      oy_d;
  logic [ADDR_W-1:0]   fetch_addr_d, win_addr_d, dst_addr_d;
  logic [ACC_W-1:0]    acc_sum_d;
  logic [DATA_W-1:0]   pix_d;

`ifdef DS_ROUND_EN
  localparam int unsigned RND_W = ACC_W + 1;
  localparam int unsigned HALF  = 1 << (SHIFT - 1);
  logic [RND_W-1:0]    rnd_sum, rnd_shr;
`endif

  function automatic logic [ADDR_W-1:0] src_addr(
    input logic [OXW-1:0] ox,
    input logic [OYW-1:0] oy,
    input logic [WXW-1:0] wx,
    input logic [WXW-1:0] wy
  );
    return ADDR_W'(SRC_BASE + (32'(oy) * FACTOR + 32'(wy)) * IMG_W
                   + 32'(ox) * FACTOR + 32'(wx));
  endfunction

  always_comb begin
    wx_last      = (wx_q == WXW'(FACTOR - 1));
    wy_last      = (wy_q == WXW'(FACTOR - 1));
    last_tap     = wx_last && wy_last;
    ox_last      = (ox_q == OXW'(OUT_X - 1));
    oy_last      = (oy_q == OYW'(OUT_Y - 1));
    wx_d         = wx_last ? '0 : wx_q + WXW'(1);
    wy_d         = wx_last ? wy_q + WXW'(1) : wy_q;
    ox_d         = ox_last ? '0 : ox_q + OXW'(1);
    oy_d         = ox_last ? oy_q + OYW'(1) : oy_q;
    fetch_addr_d = src_addr(ox_q, oy_q, wx_d, wy_d);
    win_addr_d   = src_addr(ox_d, oy_d, '0, '0);
    dst_addr_d   = ADDR_W'(DST_BASE + 32'(oy_q) * OUT_X + 32'(ox_q));
    // The final sample lands during DRAIN, so the output pixel is formed from acc + rd_data.
    acc_sum_d    = acc_q + ACC_W'(rd_data);
`ifdef DS_ROUND_EN
    rnd_sum      = RND_W'(acc_sum_d) + RND_W'(HALF);
    rnd_shr      = rnd_sum >> SHIFT;
    pix_d        = (|rnd_shr[RND_W-1:DATA_W]) ? '1 : rnd_shr[DATA_W-1:0];
`else
    pix_d        = DATA_W'(acc_sum_d >> SHIFT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ox_q      <= '0;
      oy_q      <= '0;
      wx_q      <= '0;
      wy_q      <= '0;
      acc_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rd_vld_q <= rd_en_q;
      if (rd_vld_q) acc_q <= acc_sum_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_FETCH;
            ox_q      <= '0;
            oy_q      <= '0;
            wx_q      <= '0;
            wy_q      <= '0;
            acc_q     <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= ADDR_W'(SRC_BASE);
            busy_q    <= 1'b1;
          end
        end
        S_FETCH: begin
          if (last_tap) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            wx_q      <= wx_d;
            wy_q      <= wy_d;
            rd_addr_q <= fetch_addr_d;
          end
        end
        S_DRAIN: begin
          state_q   <= S_WRITE;
          wr_en_q   <= 1'b1;
          wr_addr_q <= dst_addr_d;
          wr_data_q <= pix_d;
          wx_q      <= '0;
          wy_q      <= '0;
        end
        S_WRITE: begin
          wr_en_q <= 1'b0;
          acc_q   <= '0;
          if (ox_last && oy_last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
          end else begin
            state_q   <= S_FETCH;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= win_addr_d;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_downsample_engine.sv
// tb_downsample_engine: directed + randomized bench for downsample_engine against an arithmetic window-average model.
module tb_downsample_engine;

  localparam int unsigned W0 = 8, H0 = 4, F0 = 2, S0 = 32'h0100, D0 = 32'h4000;
  localparam int unsigned W1 = 8, H1 = 8, F1 = 4, S1 = 32'h0800, D1 = 32'h5000;
  localparam int unsigned N0 = (W0 * H0 / (F0 * F0)) * (F0 * F0 + 2);
  localparam int unsigned N1 = (W1 * H1 / (F1 * F1)) * (F1 * F1 + 2);
`ifdef DS_ROUND_EN
  localparam int unsigned WIN1234 = 3;
`else
  localparam int unsigned WIN1234 = 2;
`endif

  logic        clk, rst_n, start0, start1;
  logic        rd_en0, wr_en0, busy0, done0, rd_en1, wr_en1, busy1, done1;
  logic [15:0] rd_addr0, wr_addr0, rd_addr1, wr_addr1;
  logic [7:0]  rd_data0, wr_data0, rd_data1, wr_data1;
  logic [2:0]  state0, state1;

  logic [7:0]  mem [0:65535];
  logic [15:0] wa0[$], rdq0[$], wa1[$], rdq1[$], ea[$], er[$];
  logic [7:0]  wd0[$], wd1[$], ed[$];
  int unsigned dcnt0, dcnt1, ovl;
  int unsigned checks = 0;
  int unsigned errors = 0;

  downsample_engine #(.DATA_W(8), .ADDR_W(16), .IMG_W(W0), .IMG_H(H0), .FACTOR(F0),
                      .SRC_BASE(S0), .DST_BASE(D0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .rd_en(rd_en0), .rd_addr(rd_addr0),
    .rd_data(rd_data0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0), .STATE(state0));

  downsample_engine #(.DATA_W(8), .ADDR_W(16), .IMG_W(W1), .IMG_H(H1), .FACTOR(F1),
                      .SRC_BASE(S1), .DST_BASE(D1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1), .STATE(state1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model (one-cycle read latency) plus write/read/done logging.
  always @(posedge clk) begin
    if (rd_en0) begin rd_data0 <= mem[rd_addr0]; rdq0.push_back(rd_addr0); end
    if (rd_en1) begin rd_data1 <= mem[rd_addr1]; rdq1.push_back(rd_addr1); end
    if (wr_en0) begin wa0.push_back(wr_addr0); wd0.push_back(wr_data0); end
    if (wr_en1) begin wa1.push_back(wr_addr1); wd1.push_back(wr_data1); end
    if ((rd_en0 && wr_en0) || (rd_en1 && wr_en1)) ovl++;
    if (done0) dcnt0++;
    if (done1) dcnt1++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] g_state(input int id);
    return (id == 0) ? 32'(state0) : 32'(state1);
  endfunction
  function automatic logic [31:0] g_busy(input int id);
    return (id == 0) ? 32'(busy0) : 32'(busy1);
  endfunction
  function automatic logic [31:0] g_done(input int id);
    return (id == 0) ? 32'(done0) : 32'(done1);
  endfunction
  function automatic logic [31:0] g_rden(input int id);
    return (id == 0) ? 32'(rd_en0) : 32'(rd_en1);
  endfunction
  function automatic logic [31:0] g_rdaddr(input int id);
    return (id == 0) ? 32'(rd_addr0) : 32'(rd_addr1);
  endfunction

  task automatic set_start(input int id, input logic v);
    if (id == 0) start0 = v; else start1 = v;
  endtask

  task automatic chk_zero(input int id, input string tag);
    if (id == 0) begin
      chk({tag, "/ctrl0"}, 32'({state0, rd_en0, wr_en0, busy0, done0}), 0);
      chk({tag, "/addr0"}, {rd_addr0, wr_addr0}, 0);
      chk({tag, "/wdata0"}, 32'(wr_data0), 0);
    end else begin
      chk({tag, "/ctrl1"}, 32'({state1, rd_en1, wr_en1, busy1, done1}), 0);
      chk({tag, "/addr1"}, {rd_addr1, wr_addr1}, 0);
      chk({tag, "/wdata1"}, 32'(wr_data1), 0);
    end
  endtask

  task automatic fill_rand(input int unsigned base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) mem[base + i] = 8'($urandom);
  endtask

  // Reference: each output pixel is the (truncated or rounded) mean of its window.
  task automatic build_exp(input int unsigned src, input int unsigned dst, input int unsigned w,
                           input int unsigned h, input int unsigned f);
    int unsigned sum, avg, a;
    ea.delete(); ed.delete(); er.delete();
    for (int unsigned oy = 0; oy < h / f; oy++)
      for (int unsigned ox = 0; ox < w / f; ox++) begin
        sum = 0;
        for (int unsigned wy = 0; wy < f; wy++)
          for (int unsigned wx = 0; wx < f; wx++) begin
            a = src + (oy * f + wy) * w + ox * f + wx;
            er.push_back(16'(a));
            sum += 32'(mem[a]);
          end
`ifdef DS_ROUND_EN
        avg = (sum + f * f / 2) / (f * f);
        if (avg > 255) avg = 255;
`else
        avg = sum / (f * f);
`endif
        ea.push_back(16'(dst + oy * (w / f) + ox));
        ed.push_back(8'(avg));
      end
  endtask

  task automatic clear_logs(input int id);
    if (id == 0) begin wa0.delete(); wd0.delete(); rdq0.delete(); dcnt0 = 0; end
    else begin wa1.delete(); wd1.delete(); rdq1.delete(); dcnt1 = 0; end
    ovl = 0;
  endtask

  task automatic run(input int id, input int unsigned expn, input int unsigned src);
    int unsigned n, bc;
    clear_logs(id);
    @(posedge clk); #1 set_start(id, 1'b1);
    @(posedge clk); #1 set_start(id, 1'b0);
    chk($sformatf("run%0d/first_state", id), g_state(id), 1);
    chk($sformatf("run%0d/first_busy", id), g_busy(id), 1);
    chk($sformatf("run%0d/first_rden", id), g_rden(id), 1);
    chk($sformatf("run%0d/first_rdaddr", id), g_rdaddr(id), src);
    n = 1; bc = 0;
    forever begin
      if (g_busy(id) == 1) bc++;
      if (g_done(id) == 1 || n >= expn + 20) break;
      set_start(id, n == 10);
      @(posedge clk); #1 n++;
    end
    chk($sformatf("run%0d/done_seen", id), g_done(id), 1);
    chk($sformatf("run%0d/done_cycle", id), n, expn + 1);
    chk($sformatf("run%0d/busy_cycles", id), bc, expn);
    set_start(id, 1'b1);
    @(posedge clk); #1 set_start(id, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("run%0d/idle_state", id), g_state(id), 0);
      chk($sformatf("run%0d/idle_busy", id), g_busy(id), 0);
      @(posedge clk); #1;
    end
    chk($sformatf("run%0d/done_pulses", id), (id == 0) ? dcnt0 : dcnt1, 1);
    chk($sformatf("run%0d/rd_wr_overlap", id), ovl, 0);
  endtask

  task automatic cmp_run(input string tag, input int id);
    logic [15:0] wa[$], rq[$];
    logic [7:0]  wd[$];
    if (id == 0) begin wa = wa0; wd = wd0; rq = rdq0; end
    else begin wa = wa1; wd = wd1; rq = rdq1; end
    chk({tag, "/n_writes"}, 32'(wa.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      chk($sformatf("%s/wr_addr[%0d]", tag, i), 32'(wa[i]), 32'(ea[i]));
      chk($sformatf("%s/wr_data[%0d]", tag, i), 32'(wd[i]), 32'(ed[i]));
    end
    chk({tag, "/n_reads"}, 32'(rq.size()), 32'(er.size()));
    for (int i = 0; i < er.size() && i < rq.size(); i++)
      chk($sformatf("%s/rd_addr[%0d]", tag, i), 32'(rq[i]), 32'(er[i]));
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    dcnt0 = 0; dcnt1 = 0; ovl = 0;
    fill_rand(S0, W0 * H0);
    mem[S0] = 8'd1; mem[S0 + 1] = 8'd2; mem[S0 + W0] = 8'd3; mem[S0 + W0 + 1] = 8'd4;
    repeat (3) @(posedge clk);
    #1 chk_zero(0, "reset"); chk_zero(1, "reset");
    rst_n = 1'b1;
    @(posedge clk); #1 chk_zero(0, "post_reset");

    // u0: 8x4 image, factor 2, random data with a 1,2,3,4 first window
    build_exp(S0, D0, W0, H0, F0);
    run(0, N0, S0);
    cmp_run("u0_rand", 0);
    chk("u0/win1234", 32'(wd0[0]), WIN1234);
    chk("u0/sweep_rd0", 32'(rdq0[20]), S0 + 18);
    chk("u0/sweep_rd1", 32'(rdq0[21]), S0 + 19);
    chk("u0/sweep_rd2", 32'(rdq0[22]), S0 + 26);
    chk("u0/sweep_rd3", 32'(rdq0[23]), S0 + 27);
    chk("u0/sweep_wr", 32'(wa0[5]), D0 + 5);

    // u1: factor 4, saturated input
    for (int unsigned i = 0; i < W1 * H1; i++) mem[S1 + i] = 8'hFF;
    build_exp(S1, D1, W1, H1, F1);
    run(1, N1, S1);
    cmp_run("u1_ff", 1);
    for (int i = 0; i < wd1.size(); i++) chk($sformatf("u1_ff/pix[%0d]", i), 32'(wd1[i]), 32'hFF);

    // u1: factor 4, random data
    fill_rand(S1, W1 * H1);
    build_exp(S1, D1, W1, H1, F1);
    run(1, N1, S1);
    cmp_run("u1_rand", 1);

    // u0: reset during FETCH of the third window, then a clean rerun
    fill_rand(S0, W0 * H0);
    build_exp(S0, D0, W0, H0, F0);
    clear_logs(0);
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    for (int n = 0; n < 200 && wa0.size() < 2; n++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid/two_writes", 32'(wa0.size()), 2);
    chk("rst_mid/in_fetch", 32'(state0), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero(0, "rst_mid");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("rst_mid/no_more_writes", 32'(wa0.size()), 2);
    chk("rst_mid/idle", 32'(state0), 0);
    chk("rst_mid/not_busy", 32'(busy0), 0);
    run(0, N0, S0);
    cmp_run("u0_after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
